mem_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 32x32 single-port memory between NUM_REQ requesters.
- Accepts one read or write command at a time, drives the memory's Wr_En/Rd_En/Address/Data_in, and returns read data to the requester that issued the read.
- Guarantees the memory never sees Wr_En and Rd_En high in the same cycle.
- Sits between client blocks and the memory instance.

---
 rtl/mem_req_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Round-robin arbiter and sequencer that shares one single-port memory
//   between NUM_REQ requesters, one command at a time. Reads return data to
//   the issuing requester. The two memory enables are never high together.
//
// Ports
//   CLK, Rst          clock (rising edge), synchronous active-high reset
//   Req/Req_wr        per-requester request and type (1 = write)
//   Req_addr/wdata    flattened per-requester address / write data
//   Gnt               one-hot pulse, command of requester k accepted
//   Rd_data/valid/err read return (data, one-hot owner, memory gave no valid)
//   Busy              high whenever the sequencer is not IDLE
//   Mem_*             connection to the memory instance
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | sample Req, pick round-robin winner and latch its command
// ISSUE   | Gnt pulse, exactly one memory enable asserted
// WAIT_RD | enables low, capture memory data/valid at end of cycle
// RETURN  | Rd_valid pulse to the requester that issued the read

module mem_req_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 2
) (
  input  logic                           CLK,
  input  logic                           Rst,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ-1:0]             Req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  Req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  Req_wdata,
  output logic [NUM_REQ-1:0]             Gnt,
  output logic [DATA_WIDTH-1:0]          Rd_data,
  output logic [NUM_REQ-1:0]             Rd_valid,
  output logic                           Rd_err,
  output logic                           Busy,
  output logic                           Mem_Wr_En,
  output logic                           Mem_Rd_En,
  output logic [ADDR_WIDTH-1:0]          Mem_Address,
  output logic [DATA_WIDTH-1:0]          Mem_Data_in,
  input  logic [DATA_WIDTH-1:0]          Mem_Data_out,
  input  logic                           Mem_Valid_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RETURN} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_gnt;
  logic [IDX_W-1:0] cur;
  logic             cur_wr;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             win_vld;

  // Scan from the farthest candidate to the nearest so the requester closest
  // after last_gnt overwrites any earlier hit and ends up as the winner.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_gnt) + i) % NUM_REQ);
      if (Req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state       <= IDLE;
      last_gnt    <= IDX_W'(NUM_REQ - 1);
      cur         <= '0;
      cur_wr      <= 1'b0;
      Gnt         <= '0;
      Rd_data     <= '0;
      Rd_valid    <= '0;
      Rd_err      <= 1'b0;
      Busy        <= 1'b0;
      Mem_Wr_En   <= 1'b0;
      Mem_Rd_En   <= 1'b0;
      Mem_Address <= '0;
      Mem_Data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            cur         <= win;
            cur_wr      <= Req_wr[win];
            last_gnt    <= win;
            Gnt         <= NUM_REQ'(1) << win;
            Mem_Wr_En   <= Req_wr[win];
            Mem_Rd_En   <= ~Req_wr[win];
            Mem_Address <= Req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            Mem_Data_in <= Req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
            Busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Mem_Address intentionally keeps its value after the access.
          Gnt         <= '0;
          Mem_Wr_En   <= 1'b0;
          Mem_Rd_En   <= 1'b0;
          Mem_Data_in <= '0;
          if (cur_wr) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          Rd_valid <= NUM_REQ'(1) << cur;
          Rd_data  <= Mem_Valid_out ? Mem_Data_out : '0;
          Rd_err   <= ~Mem_Valid_out;
          state    <= RETURN;
        end
        RETURN: begin
          Rd_valid <= '0;
          Rd_data  <= '0;
          Rd_err   <= 1'b0;
          Busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            CLK = 1'b0;
  logic            Rst;
  logic [NR-1:0]   Req, Req_wr;
  logic [NR*AW-1:0] Req_addr;
  logic [NR*DW-1:0] Req_wdata;
  logic [NR-1:0]   Gnt, Rd_valid;
  logic [DW-1:0]   Rd_data;
  logic            Rd_err, Busy;
  logic            Mem_Wr_En, Mem_Rd_En;
  logic [AW-1:0]   Mem_Address;
  logic [DW-1:0]   Mem_Data_in, Mem_Data_out;
  logic            Mem_Valid_out;

  mem_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .CLK(CLK), .Rst(Rst), .Req(Req), .Req_wr(Req_wr), .Req_addr(Req_addr),
    .Req_wdata(Req_wdata), .Gnt(Gnt), .Rd_data(Rd_data), .Rd_valid(Rd_valid),
    .Rd_err(Rd_err), .Busy(Busy), .Mem_Wr_En(Mem_Wr_En), .Mem_Rd_En(Mem_Rd_En),
    .Mem_Address(Mem_Address), .Mem_Data_in(Mem_Data_in),
    .Mem_Data_out(Mem_Data_out), .Mem_Valid_out(Mem_Valid_out)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // memory model: one-cycle read latency, valid can be suppressed
  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  logic          kill_valid = 1'b0;

  always @(posedge CLK) begin
    if (Mem_Wr_En) mem[Mem_Address] <= Mem_Data_in;
    Mem_Valid_out <= Mem_Rd_En && !kill_valid;
    Mem_Data_out  <= Mem_Rd_En ? mem[Mem_Address] : '0;
  end

  // scoreboard
  typedef struct {
    logic [NR-1:0] gnt;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;
  typedef struct {
    logic [NR-1:0] rv;
    logic [DW-1:0] data;
    logic          err;
  } rd_t;

  gnt_t gnt_q[$];
  rd_t  rd_q[$];
  int   cyc = 0;
  int   rd_gnt_cyc = 0;
  int   tb_last = NR - 1;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!Rst) begin
      chk("wr_rd_excl", 64'(Mem_Wr_En & Mem_Rd_En), 0);
      chk("gnt_rv_excl", 64'((|Gnt) & (|Rd_valid)), 0);
      if (Gnt != '0) begin
        if (gnt_q.size() == 0) chk("unexp_gnt", 64'(Gnt), 0);
        else begin
          gnt_t e;
          e = gnt_q.pop_front();
          chk("gnt", 64'(Gnt), 64'(e.gnt));
          chk("mem_wr_en", 64'(Mem_Wr_En), 64'(e.wr));
          chk("mem_rd_en", 64'(Mem_Rd_En), 64'(!e.wr));
          chk("mem_addr", 64'(Mem_Address), 64'(e.addr));
          chk("mem_din", 64'(Mem_Data_in), 64'(e.wdata));
          chk("busy_issue", 64'(Busy), 1);
          if (!e.wr) rd_gnt_cyc = cyc;
        end
      end else begin
        chk("en_idle", 64'({Mem_Wr_En, Mem_Rd_En}), 0);
        chk("din_idle", 64'(Mem_Data_in), 0);
      end
      if (Rd_valid != '0) begin
        if (rd_q.size() == 0) chk("unexp_rd_valid", 64'(Rd_valid), 0);
        else begin
          rd_t r;
          r = rd_q.pop_front();
          chk("rd_valid", 64'(Rd_valid), 64'(r.rv));
          chk("rd_data", 64'(Rd_data), 64'(r.data));
          chk("rd_err", 64'(Rd_err), 64'(r.err));
          chk("rd_latency", 64'(cyc - rd_gnt_cyc), 2);
        end
      end else begin
        chk("rd_data_idle", 64'(Rd_data), 0);
        chk("rd_err_idle", 64'(Rd_err), 0);
      end
    end
  end

  task automatic set_cmd(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    Req_wr[k] = wr;
    Req_addr[k*AW +: AW] = a;
    Req_wdata[k*DW +: DW] = d;
  endtask

  // expected entries for one accepted command, with reference memory update
  task automatic expect_cmd(input int k, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic no_valid);
    gnt_t e;
    rd_t  r;
    e.gnt = NR'(1) << k; e.wr = wr; e.addr = a; e.wdata = d;
    gnt_q.push_back(e);
    if (wr) ref_mem[a] = d;
    else begin
      r.rv = NR'(1) << k;
      r.data = no_valid ? '0 : ref_mem[a];
      r.err = no_valid;
      rd_q.push_back(r);
    end
    tb_last = k;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge CLK);
      if (!Busy && gnt_q.size() == 0 && rd_q.size() == 0) done = 1;
    end
    chk("drain", 64'(done), 1);
  endtask

  task automatic do_cmd(input int k, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic no_valid);
    bit seen = 0;
    @(negedge CLK);
    set_cmd(k, wr, a, d);
    Req[k] = 1'b1;
    kill_valid = no_valid;
    expect_cmd(k, wr, a, d, no_valid);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (Gnt[k]) seen = 1;
    end
    chk("gnt_seen", 64'(seen), 1);
    Req[k] = 1'b0;
    wait_drain();
    kill_valid = 1'b0;
  endtask

  // both requesters read continuously until each got n grants
  task automatic contend(input int n, input logic [AW-1:0] a);
    int pend[NR];
    int cnt[NR];
    int last;
    int got = 0;
    for (int k = 0; k < NR; k++) begin pend[k] = n; cnt[k] = 0; end
    last = tb_last;
    for (int g = 0; g < NR*n; g++) begin
      for (int i = 1; i <= NR; i++) begin
        int c;
        c = (last + i) % NR;
        if (pend[c] > 0) begin
          pend[c]--; last = c;
          expect_cmd(c, 1'b0, a, 32'h100 + c, 1'b0);
          break;
        end
      end
    end
    @(negedge CLK);
    for (int k = 0; k < NR; k++) set_cmd(k, 1'b0, a, 32'h100 + k);
    Req = '1;
    for (int i = 0; i < 100 && got < NR*n; i++) begin
      @(negedge CLK);
      for (int k = 0; k < NR; k++)
        if (Gnt[k]) begin
          cnt[k]++; got++;
          if (cnt[k] == n) Req[k] = 1'b0;
        end
    end
    chk("contend_grants", 64'(got), 64'(NR*n));
    Req = '0;
    wait_drain();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    Req = '0; Req_wr = '0; Req_addr = '0; Req_wdata = '0;
    Rst = 1'b1;

    // reset with requests pending
    @(negedge CLK);
    Req = 2'b11;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_ctrl", 64'({Gnt, Rd_valid, Rd_err, Busy, Mem_Wr_En, Mem_Rd_En, Mem_Address}), 0);
      chk("rst_data", 64'({Rd_data, Mem_Data_in}), 0);
    end
    Req = '0;
    Rst = 1'b0;
    tb_last = NR - 1;
    contend(1, 5'd0);

    // single write then read, requester 0
    do_cmd(0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    do_cmd(0, 1'b0, 5'd5, 32'h0, 1'b0);

    // contention on addr 31
    do_cmd(0, 1'b1, 5'd31, 32'h12345678, 1'b0);
    contend(2, 5'd31);

    // address extremes
    do_cmd(1, 1'b1, 5'd0,  32'hA5A5A5A5, 1'b0);
    do_cmd(1, 1'b1, 5'd31, 32'h5A5A5A5A, 1'b0);
    do_cmd(0, 1'b0, 5'd0,  32'h0, 1'b0);
    do_cmd(0, 1'b0, 5'd31, 32'h0, 1'b0);

    // memory does not return valid
    do_cmd(1, 1'b0, 5'd5, 32'h0, 1'b1);

    // reset during WAIT_RD: grant expected, read return must never appear
    begin
      gnt_t e;
      bit seen = 0;
      @(negedge CLK);
      set_cmd(1, 1'b0, 5'd5, 32'h77);
      Req[1] = 1'b1;
      e.gnt = 2'b10; e.wr = 1'b0; e.addr = 5'd5; e.wdata = 32'h77;
      gnt_q.push_back(e);
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge CLK);
        if (Gnt[1]) seen = 1;
      end
      chk("gnt_seen_rst", 64'(seen), 1);
      Req[1] = 1'b0;
      @(negedge CLK);
      Rst = 1'b1;
      @(negedge CLK);
      chk("rst_mid_busy", 64'(Busy), 0);
      chk("rst_mid_rv", 64'(Rd_valid), 0);
      Rst = 1'b0;
      tb_last = NR - 1;
      repeat (3) @(negedge CLK);
      chk("rst_mid_idle", 64'(Busy), 0);
    end
    contend(1, 5'd5);

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
